rr_mux_arbiter: RTL and testbench

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

---
 rtl/mux_arb_pkg.sv | 19 +
 rtl/rr_pick8.sv | 28 ++
 rtl/rr_mux_arbiter.sv | 91 +++++++++
 tb/tb_rr_mux_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared sizes, FSM state type and one-hot helper for the round-robin mux arbiter
package mux_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational round-robin pick over 8 requesters, starting after last_grant
module rr_pick8
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last_grant,
  output logic               found,
  output logic [SEL_W-1:0]   winner
);

  logic [SEL_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest set bit after last_grant wins;
  // offset NUM_REQ wraps to last_grant itself, giving it the lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last_grant + SEL_W'(k);
      if (req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - 8-way round-robin arbiter registering the granted byte behind a valid/ready output
module rr_mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [SEL_W-1:0]          out_src
);

  state_t             state;
  logic [SEL_W-1:0]   last_grant;
  logic               handshake;
  logic [NUM_REQ-1:0] arb_req;
  logic               found;
  logic [SEL_W-1:0]   winner;
  logic [DATA_W-1:0]  win_data;

  assign handshake = out_valid & out_ready;
  // The requester being acked is excluded from the same-cycle re-arbitration.
  assign arb_req   = handshake ? (req & ~onehot8(out_src)) : req;
  assign ack       = handshake ? onehot8(out_src) : '0;

  rr_pick8 u_pick (
    .req        (arb_req),
    .last_grant (last_grant),
    .found      (found),
    .winner     (winner)
  );

  always_comb begin
    win_data = '0;
    case (winner)
      3'd0:    win_data = data[0*DATA_W +: DATA_W];
      3'd1:    win_data = data[1*DATA_W +: DATA_W];
      3'd2:    win_data = data[2*DATA_W +: DATA_W];
      3'd3:    win_data = data[3*DATA_W +: DATA_W];
      3'd4:    win_data = data[4*DATA_W +: DATA_W];
      3'd5:    win_data = data[5*DATA_W +: DATA_W];
      3'd6:    win_data = data[6*DATA_W +: DATA_W];
      3'd7:    win_data = data[7*DATA_W +: DATA_W];
      default: win_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      last_grant <= SEL_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state      <= HOLD;
            out_valid  <= 1'b1;
            out_data   <= win_data;
            out_src    <= winner;
            last_grant <= winner;
          end
        end
        HOLD: begin
          if (handshake) begin
            if (found) begin
              out_data   <= win_data;
              out_src    <= winner;
              last_grant <= winner;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - directed scoreboard bench for rr_mux_arbiter
module tb_rr_mux_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  req;
  logic [63:0] data;
  logic [7:0]  ack;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_src;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [2:0] src;
    logic [7:0] dat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  rr_mux_arbiter #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data      (data),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_byte(input int i, input logic [7:0] v);
    data[i*8 +: 8] = v;
  endtask

  task automatic push(input logic [2:0] s, input logic [7:0] d);
    exp_t e;
    e.src = s;
    e.dat = d;
    sb.push_back(e);
  endtask

  // Check outputs mid-cycle, retire a scoreboard entry on each handshake, then advance one clock.
  task automatic cycle();
    exp_t e;
    logic [7:0] exp_ack;
    @(negedge clk);
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_handshake", 32'(out_src), 32'hFF);
      end else begin
        e       = sb.pop_front();
        exp_ack = 8'h01 << e.src;
        chk("sb_src", 32'(out_src), 32'(e.src));
        chk("sb_data", 32'(out_data), 32'(e.dat));
        chk("sb_ack", 32'(ack), 32'(exp_ack));
      end
    end else begin
      chk("ack_idle", 32'(ack), 32'h0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = 8'h00;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) set_byte(i, 8'(10 * i + 100));
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_src", 32'(out_src), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 8'h00;
    data      = '0;
    out_ready = 1'b0;

    // single request, out_ready already high while idle
    do_reset();
    req       = 8'h01;
    out_ready = 1'b1;
    push(3'd0, 8'd100);
    cycle();
    chk("single_valid", 32'(out_valid), 32'h1);
    req = 8'h00;
    cycle();
    cycle();
    chk("single_back_idle", 32'(out_valid), 32'h0);

    // all requesting: 0..7 then 0, no bubbles
    do_reset();
    req       = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(3'(i), 8'(10 * i + 100));
    push(3'd0, 8'd100);
    cycle();
    for (int i = 0; i < 9; i++) begin
      chk("rr_no_bubble", 32'(out_valid), 32'h1);
      cycle();
    end
    out_ready = 1'b0;
    req       = 8'h00;

    // stall with out_ready low, then release
    do_reset();
    req = 8'h24;
    push(3'd2, 8'd120);
    push(3'd5, 8'd150);
    cycle();
    for (int i = 0; i < 5; i++) begin
      chk("stall_src", 32'(out_src), 32'h2);
      chk("stall_data", 32'(out_data), 32'd120);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    req = 8'h00;
    chk("stall_next_src", 32'(out_src), 32'h5);
    cycle();
    cycle();
    chk("stall_idle", 32'(out_valid), 32'h0);

    // wrap from 7 back to 0
    do_reset();
    req       = 8'h80;
    out_ready = 1'b1;
    push(3'd7, 8'd170);
    cycle();
    req = 8'h81;
    push(3'd0, 8'd100);
    push(3'd7, 8'd170);
    cycle();
    cycle();
    req = 8'h00;
    cycle();
    cycle();
    chk("wrap_idle", 32'(out_valid), 32'h0);

    // reset while holding requester 5
    do_reset();
    req = 8'h20;
    cycle();
    chk("hold5_valid", 32'(out_valid), 32'h1);
    chk("hold5_src", 32'(out_src), 32'h5);
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_ack", 32'(ack), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 8'h21;
    push(3'd0, 8'd100);
    cycle();
    req = 8'h00;
    cycle();
    cycle();

    // data change during hold is ignored
    do_reset();
    set_byte(2, 8'd130);
    req = 8'h04;
    push(3'd2, 8'd130);
    cycle();
    set_byte(2, 8'd170);
    for (int i = 0; i < 3; i++) begin
      chk("hold_data_stable", 32'(out_data), 32'd130);
      cycle();
    end
    req       = 8'h00;
    out_ready = 1'b1;
    cycle();
    cycle();

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
